// File: rtl/cfi_pkg.sv
// Shared types for the CFI return checker: commit-log entry, fault record,
// statistics block and checker FSM state.
package cfi_pkg;

  localparam int unsigned VLEN = 32;

  typedef struct packed {
    logic branch;
    logic jump;
    logic call;
    logic ret;
  } cfi_flags_t;

  typedef struct packed {
    cfi_flags_t       flags;
    logic [VLEN-1:0]  addr_pc;
    logic [VLEN-1:0]  addr_npc;
    logic [VLEN-1:0]  addr_target;
  } cfi_log_t;

  typedef struct packed {
    logic             valid;
    logic [VLEN-1:0]  pc;
    logic [VLEN-1:0]  expected;
    logic [VLEN-1:0]  actual;
  } cfi_fault_t;

  typedef struct packed {
    logic [31:0] calls;
    logic [31:0] rets;
    logic [31:0] faults;
  } cfi_stats_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_FAULT
  } cfi_state_e;

endpackage

// File: rtl/cfi_log_fifo.sv
// Multi-write, single-read log queue: qualified ports are packed in ascending
// order into free slots; ports that do not fit are dropped from the top down.
module cfi_log_fifo
  import cfi_pkg::*;
#(
  parameter int unsigned NR_PORTS = 2,
  parameter int unsigned DEPTH    = 8,
  localparam int unsigned PW      = $clog2(DEPTH),
  localparam int unsigned CW      = PW + 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic     [NR_PORTS-1:0] wr_valid_i,
  input  cfi_log_t [NR_PORTS-1:0] wr_data_i,
  input  logic                    rd_en_i,
  output cfi_log_t                rd_data_o,
  output logic     [CW-1:0]       count_o,
  output logic     [CW-1:0]       n_wr_o,
  output logic                    drop_o
);

  cfi_log_t          mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d, free;
  logic [CW-1:0]     n_wr;
  logic [NR_PORTS-1:0] wr_en;
  logic [PW-1:0]     wr_idx [NR_PORTS];

  // Free space excludes a same-cycle pop so acceptance never depends on the checker.
  always_comb begin
    free   = CW'(DEPTH) - count_q;
    n_wr   = '0;
    drop_o = 1'b0;
    wr_en  = '0;
    for (int unsigned i = 0; i < NR_PORTS; i++) begin
      wr_idx[i] = wr_ptr_q + PW'(n_wr);
      if (wr_valid_i[i]) begin
        if (n_wr < free) begin
          wr_en[i] = 1'b1;
          n_wr     = n_wr + CW'(1);
        end else begin
          drop_o = 1'b1;
        end
      end
    end
    wr_ptr_d = wr_ptr_q + PW'(n_wr);
    rd_ptr_d = rd_ptr_q + PW'(rd_en_i);
    count_d  = count_q + n_wr - CW'(rd_en_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < NR_PORTS; i++) begin
      if (wr_en[i]) mem_q[wr_idx[i]] <= wr_data_i[i];
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;
  assign n_wr_o    = n_wr;

endmodule

// File: rtl/cfi_ret_checker.sv
// Shadow-stack return checker fed from the commit log queue.
// Optional counters: define CFI_RET_CHECKER_STATS_EN.
module cfi_ret_checker
  import cfi_pkg::*;
#(
  parameter int unsigned NR_COMMIT_PORTS = 2,
  parameter int unsigned FIFO_DEPTH      = 8,
  parameter int unsigned STACK_DEPTH     = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  cfi_log_t [NR_COMMIT_PORTS-1:0] log_i,
  input  logic     [NR_COMMIT_PORTS-1:0] cfi_i,
  output logic                           stall_o,
  output cfi_fault_t                     fault_o,
  input  logic                           fault_ack_i,
  output logic                           lost_o,
  output logic                           busy_o,
  output cfi_stats_t                     stats_o
);

  localparam int unsigned CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SPW = $clog2(STACK_DEPTH);
  localparam int unsigned SCW = SPW + 1;

  cfi_state_e    state_q, state_d;
  logic          pop, drop;
  cfi_log_t      ent;
  logic [CW-1:0] count, n_wr;

  cfi_log_fifo #(
    .NR_PORTS (NR_COMMIT_PORTS),
    .DEPTH    (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .wr_valid_i (cfi_i),
    .wr_data_i  (log_i),
    .rd_en_i    (pop),
    .rd_data_o  (ent),
    .count_o    (count),
    .n_wr_o     (n_wr),
    .drop_o     (drop)
  );

  logic [VLEN-1:0] stk_mem_q [STACK_DEPTH];
  logic [SPW-1:0]  sp_q, sp_d, sp_pop;
  logic [SCW-1:0]  scnt_q, scnt_d, scnt_pop;
  logic [VLEN-1:0] top;
  logic            do_call, do_ret, mismatch;
  cfi_fault_t      fault_q, fault_d;
  logic            lost_q, lost_d;
  logic            unused_flags;

  assign unused_flags = ent.flags.branch ^ ent.flags.jump;

  // Ret is resolved against the current top before any push, so a coroutine
  // entry replaces the top in place; an empty stack lets a ret pass unchecked.
  always_comb begin
    do_call  = pop & ent.flags.call;
    do_ret   = pop & ent.flags.ret;
    top      = stk_mem_q[sp_q];
    mismatch = do_ret && (scnt_q != '0) && (top != ent.addr_target);
    sp_pop   = sp_q;
    scnt_pop = scnt_q;
    if (do_ret && (scnt_q != '0)) begin
      sp_pop   = sp_q - SPW'(1);
      scnt_pop = scnt_q - SCW'(1);
    end
    sp_d   = sp_pop;
    scnt_d = scnt_pop;
    if (do_call) begin
      sp_d = sp_pop + SPW'(1);
      if (scnt_pop != SCW'(STACK_DEPTH)) scnt_d = scnt_pop + SCW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (count != '0) state_d = ST_CHECK;
      ST_CHECK: begin
        if (mismatch) state_d = ST_FAULT;
        else if ((count == CW'(pop)) && (n_wr == '0)) state_d = ST_IDLE;
      end
      ST_FAULT: if (fault_ack_i) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pop    = (state_q == ST_CHECK) && (count != '0);
    busy_o = (state_q != ST_IDLE) || (count != '0);
  end

  always_comb begin
    fault_d = fault_q;
    if (mismatch) begin
      fault_d.valid    = 1'b1;
      fault_d.pc       = ent.addr_pc;
      fault_d.expected = top;
      fault_d.actual   = ent.addr_target;
    end else if ((state_q == ST_FAULT) && fault_ack_i) begin
      fault_d = '0;
    end
    lost_d = lost_q | drop;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      sp_q    <= '0;
      scnt_q  <= '0;
      fault_q <= '0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      scnt_q  <= scnt_d;
      fault_q <= fault_d;
      lost_q  <= lost_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_call) stk_mem_q[sp_d] <= ent.addr_npc;
  end

`ifdef CFI_RET_CHECKER_STATS_EN
  cfi_stats_t stats_q, stats_d;

  always_comb begin
    stats_d        = stats_q;
    stats_d.calls  = stats_q.calls + 32'(do_call);
    stats_d.rets   = stats_q.rets + 32'(do_ret);
    stats_d.faults = stats_q.faults + 32'(mismatch);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) stats_q <= '0;
    else         stats_q <= stats_d;
  end

  assign stats_o = stats_q;
`else
  assign stats_o = '0;
`endif

  assign stall_o = (CW'(FIFO_DEPTH) - count) < CW'(NR_COMMIT_PORTS);
  assign fault_o = fault_q;
  assign lost_o  = lost_q;

endmodule
